// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding-select
// encodings, sequencer states and the legal memory-latency range.
package hazard_ctrl_pkg;

  // ALU operand source select driven into the execute-stage operand muxes.
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,  // register-file read data
    FWD_MEMWB = 2'b01,  // MEM/WB write-back data
    FWD_EXMEM = 2'b10   // EX/MEM ALU result
  } fwd_sel_e;

  // Sequencer states: normal flow, or frozen behind a multi-cycle memory access.
  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } hz_state_e;

  // Legal data-memory latency range; the wait counter is 4 bits wide.
  localparam int MEM_LATENCY_MIN = 1;
  localparam int MEM_LATENCY_MAX = 16;

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Combinational forwarding unit for one ALU operand. The youngest producer
// (EX/MEM) wins over MEM/WB, and register 0 is never forwarded.
module fwd_select
  import hazard_ctrl_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] src,
  input  logic            mem_we,
  input  logic [RA_W-1:0] mem_dst,
  input  logic            wb_we,
  input  logic [RA_W-1:0] wb_dst,
  output logic [1:0]      sel
);

  // Priority select of the operand source.
  always_comb begin
    // NOTE: assign a default first so every path drives sel and no latch is inferred.
    sel = FWD_RF;
    if (mem_we && (mem_dst != '0) && (mem_dst == src)) begin
      sel = FWD_EXMEM;
    end else if (wb_we && (wb_dst != '0) && (wb_dst == src)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Central pipeline sequencer for the 5-stage core: operand forwarding,
// load-use stalls, branch flushes, memory-access freeze and a stall counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int RA_W        = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_uses_rt,
  input  logic [RA_W-1:0] ex_rs,
  input  logic [RA_W-1:0] ex_rt,
  input  logic            ex_mem_read,
  input  logic [RA_W-1:0] ex_dst,
  input  logic            mem_reg_write,
  input  logic [RA_W-1:0] mem_dst,
  input  logic            mem_access,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_dst,
  input  logic            branch_taken,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            ifid_flush,
  output logic            idex_bubble,
  output logic            pipe_hold,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic [31:0]     stall_cycles
);

  if ((MEM_LATENCY < MEM_LATENCY_MIN) || (MEM_LATENCY > MEM_LATENCY_MAX)) begin : g_bad_latency
    $error("hazard_ctrl: MEM_LATENCY out of range");
  end

  // A single-cycle memory never freezes the pipeline.
  localparam bit         FREEZE_EN = (MEM_LATENCY > 1);
  // The entry cycle is the first hold cycle, so the counter covers the rest.
  localparam logic [3:0] WAIT_INIT = FREEZE_EN ? 4'(MEM_LATENCY - 2) : 4'd0;

  hz_state_e  state;
  logic [3:0] cnt;
  logic       luse;
  logic       start_wait;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  fwd_select #(.RA_W(RA_W)) u_fwd_a (
    .src     (ex_rs),
    .mem_we  (mem_reg_write),
    .mem_dst (mem_dst),
    .wb_we   (wb_reg_write),
    .wb_dst  (wb_dst),
    .sel     (sel_a)
  );

  fwd_select #(.RA_W(RA_W)) u_fwd_b (
    .src     (ex_rt),
    .mem_we  (mem_reg_write),
    .mem_dst (mem_dst),
    .wb_we   (wb_reg_write),
    .wb_dst  (wb_dst),
    .sel     (sel_b)
  );

  // Forwarding stays live during hold; only reset forces the regfile source.
  assign fwd_a = rst ? FWD_RF : sel_a;
  assign fwd_b = rst ? FWD_RF : sel_b;

  // Load in EX whose destination feeds a source of the instruction in ID.
  assign luse = ex_mem_read && (ex_dst != '0) &&
                ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));

  // Pipeline control: freeze > flush > load-use stall > normal flow.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    start_wait  = 1'b0;
    if (rst) begin
      // Reset holds the defaults: fetch enabled, nothing flushed or frozen.
    end else if ((state == ST_MEM_WAIT) && (cnt != 4'd0)) begin
      pipe_hold  = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if ((state == ST_RUN) && mem_access && FREEZE_EN) begin
      // The release cycle (MEM_WAIT, cnt==0) skips this branch, so the
      // access still sitting in EX/MEM does not re-trigger the wait.
      pipe_hold  = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      start_wait = 1'b1;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (luse) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // Sequencer state, wait counter and saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (rst) begin
      state        <= ST_RUN;
      cnt          <= 4'd0;
      stall_cycles <= 32'd0;
    end else begin
      case (state)
        ST_RUN: begin
          if (start_wait) begin
            state <= ST_MEM_WAIT;
            cnt   <= WAIT_INIT;
          end
        end
        ST_MEM_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
      if (!pc_write && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end

endmodule
